// File: rtl/pipe_mips_core.sv
// Four-stage in-order MIPS-like core (IF, ID, EX, WB) with a loadable instruction memory.
// Hazards are resolved by a one-cycle interlock plus WB-to-ID register bypass; branches resolve in ID.
module pipe_mips_core #(
  parameter int DW      = 32,
  parameter int IMEM_AW = 10,
  parameter int DMEM_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               ld_we,
  input  logic [IMEM_AW-1:0] ld_addr,
  input  logic [31:0]        ld_data,
  input  logic [4:0]         dbg_ra,
  output logic [DW-1:0]      dbg_rd,
  output logic [IMEM_AW-1:0] pc,
  output logic               halted,
  output logic [31:0]        retired
);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LOAD  = 6'b001000;
  localparam logic [5:0] OP_STORE = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_JUMP  = 6'b010000;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  logic [31:0]   imem [2**IMEM_AW];
  logic [DW-1:0] dmem [2**DMEM_AW];
  logic [DW-1:0] rf_q [32];

  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [31:0]        ifid_instr_q, ifid_instr_d;
  logic [IMEM_AW-1:0] ifid_pc_q, ifid_pc_d;

  logic               idex_valid_q, idex_valid_d;
  logic [5:0]         idex_op_q, idex_op_d;
  logic [4:0]         idex_dest_q, idex_dest_d;
  logic               idex_we_q, idex_we_d;
  logic [DW-1:0]      idex_a_q, idex_a_d;
  logic [DW-1:0]      idex_b_q, idex_b_d;
  logic [DW-1:0]      idex_st_q, idex_st_d;

  logic               exwb_valid_q, exwb_valid_d;
  logic [5:0]         exwb_op_q, exwb_op_d;
  logic [4:0]         exwb_dest_q, exwb_dest_d;
  logic               exwb_we_q, exwb_we_d;
  logic [DW-1:0]      exwb_res_q, exwb_res_d;
  logic [DW-1:0]      exwb_st_q, exwb_st_d;

  logic               fetch_stop_q, fetch_stop_d;
  logic               halted_q, halted_d;
  logic [31:0]        retired_q, retired_d;

  logic [5:0]    id_op;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic [DW-1:0] id_imm;
  logic          id_rtype, id_iarith, uses_rs, uses_rt, id_we;
  logic [4:0]    id_dest;
  logic [DW-1:0] rs_val, rt_val;
  logic          wb_wr;
  logic [DW-1:0] wb_data;
  logic          stall, id_go, br_taken, jump, id_hlt;
  logic [IMEM_AW-1:0] br_target, jmp_target;
  logic [DW-1:0] ex_res;

  assign id_op  = ifid_instr_q[31:26];
  assign id_rs  = ifid_instr_q[25:21];
  assign id_rt  = ifid_instr_q[20:16];
  assign id_rd  = ifid_instr_q[15:11];
  assign id_imm = {{(DW-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};

  always_comb begin
    id_rtype  = 1'b0;
    id_iarith = 1'b0;
    uses_rs   = 1'b0;
    case (id_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: id_rtype = 1'b1;
      OP_ADDI, OP_SUBI, OP_SLTI:                     id_iarith = 1'b1;
      OP_LOAD, OP_STORE, OP_BEQZ, OP_BNEQZ:          uses_rs = 1'b1;
      default: ;
    endcase
    if (id_rtype || id_iarith) uses_rs = 1'b1;
    uses_rt = id_rtype || (id_op == OP_STORE);
    id_we   = id_rtype || id_iarith || (id_op == OP_LOAD);
    id_dest = id_rtype ? id_rd : id_rt;
  end

  // A register written in WB this cycle is visible to the ID read in the same cycle.
  assign wb_wr   = exwb_valid_q && exwb_we_q && (exwb_dest_q != 5'd0);
  assign wb_data = (exwb_op_q == OP_LOAD) ? dmem[exwb_res_q[DMEM_AW-1:0]] : exwb_res_q;
  assign rs_val  = (wb_wr && exwb_dest_q == id_rs) ? wb_data : rf_q[id_rs];
  assign rt_val  = (wb_wr && exwb_dest_q == id_rt) ? wb_data : rf_q[id_rt];

  assign stall = ifid_valid_q && idex_valid_q && idex_we_q && (idex_dest_q != 5'd0) &&
                 ((uses_rs && id_rs == idex_dest_q) || (uses_rt && id_rt == idex_dest_q));
  assign id_go      = ifid_valid_q && !stall;
  assign br_taken   = id_go && (((id_op == OP_BEQZ) && (rs_val == '0)) ||
                                ((id_op == OP_BNEQZ) && (rs_val != '0)));
  assign jump       = id_go && (id_op == OP_JUMP);
  assign id_hlt     = ifid_valid_q && (id_op == OP_HLT);
  assign br_target  = ifid_pc_q + IMEM_AW'(1) + id_imm[IMEM_AW-1:0];
  assign jmp_target = ifid_instr_q[IMEM_AW-1:0];

  always_comb begin
    ex_res = '0;
    case (idex_op_q)
      OP_ADD, OP_ADDI, OP_LOAD, OP_STORE: ex_res = idex_a_q + idex_b_q;
      OP_SUB, OP_SUBI:                    ex_res = idex_a_q - idex_b_q;
      OP_AND:                             ex_res = idex_a_q & idex_b_q;
      OP_OR:                              ex_res = idex_a_q | idex_b_q;
      OP_SLT, OP_SLTI: ex_res = {{(DW-1){1'b0}}, ($signed(idex_a_q) < $signed(idex_b_q))};
      OP_MUL:                             ex_res = idex_a_q * idex_b_q;
      default: ;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    // A stall holds PC and IF/ID; a pending branch waits until the stall clears.
    if (!stall) begin
      if (fetch_stop_q || id_hlt) begin
        ifid_valid_d = 1'b0;
      end else if (br_taken || jump) begin
        pc_d         = br_taken ? br_target : jmp_target;
        ifid_valid_d = 1'b0;
      end else begin
        pc_d         = pc_q + IMEM_AW'(1);
        ifid_valid_d = 1'b1;
        ifid_instr_d = imem[pc_q];
        ifid_pc_d    = pc_q;
      end
    end

    idex_valid_d = id_go;
    idex_op_d    = id_op;
    idex_dest_d  = id_dest;
    idex_we_d    = id_go && id_we;
    idex_a_d     = rs_val;
    idex_b_d     = id_rtype ? rt_val : id_imm;
    idex_st_d    = rt_val;

    exwb_valid_d = idex_valid_q;
    exwb_op_d    = idex_op_q;
    exwb_dest_d  = idex_dest_q;
    exwb_we_d    = idex_valid_q && idex_we_q;
    exwb_res_d   = ex_res;
    exwb_st_d    = idex_st_q;

    fetch_stop_d = fetch_stop_q || (id_go && id_op == OP_HLT);
    halted_d     = halted_q || (exwb_valid_q && exwb_op_q == OP_HLT);
    retired_d    = retired_q + {31'd0, exwb_valid_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      idex_valid_q <= 1'b0;
      idex_op_q    <= '0;
      idex_dest_q  <= '0;
      idex_we_q    <= 1'b0;
      idex_a_q     <= '0;
      idex_b_q     <= '0;
      idex_st_q    <= '0;
      exwb_valid_q <= 1'b0;
      exwb_op_q    <= '0;
      exwb_dest_q  <= '0;
      exwb_we_q    <= 1'b0;
      exwb_res_q   <= '0;
      exwb_st_q    <= '0;
      fetch_stop_q <= 1'b0;
      halted_q     <= 1'b0;
      retired_q    <= '0;
    end else if (en) begin
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      idex_valid_q <= idex_valid_d;
      idex_op_q    <= idex_op_d;
      idex_dest_q  <= idex_dest_d;
      idex_we_q    <= idex_we_d;
      idex_a_q     <= idex_a_d;
      idex_b_q     <= idex_b_d;
      idex_st_q    <= idex_st_d;
      exwb_valid_q <= exwb_valid_d;
      exwb_op_q    <= exwb_op_d;
      exwb_dest_q  <= exwb_dest_d;
      exwb_we_q    <= exwb_we_d;
      exwb_res_q   <= exwb_res_d;
      exwb_st_q    <= exwb_st_d;
      fetch_stop_q <= fetch_stop_d;
      halted_q     <= halted_d;
      retired_q    <= retired_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (en && wb_wr) begin
      rf_q[exwb_dest_q] <= wb_data;
    end
  end

  // Memories are never cleared; program loading works regardless of en.
  always_ff @(posedge clk) begin
    if (ld_we) imem[ld_addr] <= ld_data;
    if (!rst && en && exwb_valid_q && exwb_op_q == OP_STORE)
      dmem[exwb_res_q[DMEM_AW-1:0]] <= exwb_st_q;
  end

  assign dbg_rd  = rf_q[dbg_ra];
  assign pc      = pc_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_pipe_mips_core.sv
// Directed bench for pipe_mips_core: table-driven ALU programs plus hand-written
// hazard, branch, memory, mid-run reset and PC-wrap sequences.
module tb_pipe_mips_core;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LOAD  = 6'b001000;
  localparam logic [5:0] OP_STORE = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_JUMP  = 6'b010000;
  localparam logic [5:0] OP_UNDEF = 6'b111000;
  localparam logic [31:0] NOP = 32'h8000_0000;
  localparam logic [31:0] HLT = 32'hFC00_0000;

  logic        clk;
  logic        rst;
  logic        en;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic [4:0]  dbg_ra;
  logic [31:0] dbg_rd;
  logic [9:0]  pc;
  logic        halted;
  logic [31:0] retired;

  pipe_mips_core #(.DW(32), .IMEM_AW(10), .DMEM_AW(10)) dut (
    .clk(clk), .rst(rst), .en(en), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_ra(dbg_ra), .dbg_rd(dbg_rd), .pc(pc), .halted(halted), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        isImm;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] progBuf [16];
  int          progLen;
  int          checks = 0;
  int          errors = 0;
  int          cyc;

  function automatic logic [31:0] rInstr(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] iInstr(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic setVec(input int i, input string n, input logic [5:0] op, input logic isImm,
                        input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    vecs[i].name  = n;
    vecs[i].op    = op;
    vecs[i].isImm = isImm;
    vecs[i].a     = a;
    vecs[i].b     = b;
    vecs[i].exp   = exp;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkReg(input string name, input logic [4:0] r, input logic [31:0] exp);
    dbg_ra = r;
    #1;
    checkOutput(name, dbg_rd, exp);
  endtask

  task automatic loadWord(input logic [9:0] addr, input logic [31:0] data);
    ld_we   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    @(negedge clk);
    ld_we   = 1'b0;
  endtask

  // Loads progBuf into instruction memory with the core frozen, then resets it.
  task automatic applyStimulus();
    en = 1'b0;
    for (int i = 0; i < progLen; i++) loadWord(10'(i), progBuf[i]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic runUntilHalt(input int budget, output int cycles);
    cycles = 0;
    en = 1'b1;
    while (!halted && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    en = 1'b0;
    if (!halted) $display("[TB] FAIL halt timeout: got halted=0 expected 1 within %0d cycles", budget);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; dbg_ra = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset pc", {22'd0, pc}, 32'd0);
    checkOutput("reset halted", {31'd0, halted}, 32'd0);
    checkOutput("reset retired", retired, 32'd0);
    checkReg("reset r5", 5'd5, 32'd0);
    rst = 1'b0;

    setVec(0,  "ADD",  OP_ADD,   1'b0, 16'd10,   16'd20,   32'd30);
    setVec(1,  "SUB",  OP_SUB,   1'b0, 16'd5,    16'd7,    32'hFFFF_FFFE);
    setVec(2,  "AND",  OP_AND,   1'b0, 16'h0F0F, 16'h00FF, 32'h0000_000F);
    setVec(3,  "OR",   OP_OR,    1'b0, 16'h0F00, 16'h00F0, 32'h0000_0FF0);
    setVec(4,  "SLTn", OP_SLT,   1'b0, 16'hFFFF, 16'd1,    32'd1);
    setVec(5,  "SLTp", OP_SLT,   1'b0, 16'd1,    16'hFFFF, 32'd0);
    setVec(6,  "MULn", OP_MUL,   1'b0, 16'd300,  16'hFFFE, 32'hFFFF_FDA8);
    setVec(7,  "MULp", OP_MUL,   1'b0, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001);
    setVec(8,  "ADDI", OP_ADDI,  1'b1, 16'h7FFF, 16'h7FFF, 32'h0000_FFFE);
    setVec(9,  "SUBI", OP_SUBI,  1'b1, 16'd5,    16'd9,    32'hFFFF_FFFC);
    setVec(10, "SLTI", OP_SLTI,  1'b1, 16'hFFFB, 16'hFFFC, 32'd1);
    setVec(11, "UNDEF", OP_UNDEF, 1'b0, 16'd3,   16'd4,    32'd0);

    // Six independent instructions: no stall, HLT leaves WB on the ninth edge.
    for (int v = 0; v < 12; v++) begin
      progBuf[0] = iInstr(OP_ADDI, 5'd0, 5'd1, vecs[v].a);
      progBuf[1] = vecs[v].isImm ? NOP : iInstr(OP_ADDI, 5'd0, 5'd2, vecs[v].b);
      progBuf[2] = NOP;
      progBuf[3] = NOP;
      progBuf[4] = vecs[v].isImm ? iInstr(vecs[v].op, 5'd1, 5'd3, vecs[v].b)
                                 : rInstr(vecs[v].op, 5'd1, 5'd2, 5'd3);
      progBuf[5] = HLT;
      progLen = 6;
      applyStimulus();
      runUntilHalt(50, cyc);
      checkReg($sformatf("%s r3", vecs[v].name), 5'd3, vecs[v].exp);
      checkOutput($sformatf("%s cycles", vecs[v].name), 32'(cyc), 32'd9);
      checkOutput($sformatf("%s retired", vecs[v].name), retired, 32'd6);
    end

    // RAW interlock costs exactly one cycle.
    progBuf[0] = iInstr(OP_ADDI, 5'd0, 5'd1, 16'd5);
    progBuf[1] = rInstr(OP_ADD, 5'd1, 5'd1, 5'd2);
    progBuf[2] = HLT;
    progLen = 3;
    applyStimulus();
    runUntilHalt(50, cyc);
    checkReg("raw r2", 5'd2, 32'd10);
    checkOutput("raw cycles", 32'(cyc), 32'd7);
    checkOutput("raw retired", retired, 32'd3);

    // Taken BEQZ skips the next instruction.
    progBuf[0] = iInstr(OP_ADDI, 5'd0, 5'd1, 16'd0);
    progBuf[1] = NOP;
    progBuf[2] = iInstr(OP_BEQZ, 5'd1, 5'd0, 16'd1);
    progBuf[3] = iInstr(OP_ADDI, 5'd0, 5'd5, 16'd7);
    progBuf[4] = iInstr(OP_ADDI, 5'd0, 5'd6, 16'd9);
    progBuf[5] = HLT;
    progLen = 6;
    applyStimulus();
    runUntilHalt(50, cyc);
    checkReg("beqz r5", 5'd5, 32'd0);
    checkReg("beqz r6", 5'd6, 32'd9);
    checkOutput("beqz cycles", 32'(cyc), 32'd9);
    checkOutput("beqz retired", retired, 32'd5);

    // STORE interlocks on r1, LOAD reads back the stored word.
    progBuf[0] = iInstr(OP_ADDI, 5'd0, 5'd1, 16'hFFFD);
    progBuf[1] = iInstr(OP_STORE, 5'd0, 5'd1, 16'd4);
    progBuf[2] = iInstr(OP_LOAD, 5'd0, 5'd2, 16'd4);
    progBuf[3] = iInstr(OP_SLTI, 5'd1, 5'd3, 16'd0);
    progBuf[4] = HLT;
    progLen = 5;
    applyStimulus();
    runUntilHalt(50, cyc);
    checkReg("mem r1", 5'd1, 32'hFFFF_FFFD);
    checkReg("mem r2", 5'd2, 32'hFFFF_FFFD);
    checkReg("mem r3", 5'd3, 32'd1);
    checkOutput("mem cycles", 32'(cyc), 32'd9);
    checkOutput("mem retired", retired, 32'd5);

    // Reset while ADD r4 sits in EX.
    progBuf[0] = iInstr(OP_ADDI, 5'd0, 5'd1, 16'd3);
    progBuf[1] = iInstr(OP_ADDI, 5'd0, 5'd2, 16'd4);
    progBuf[2] = iInstr(OP_ADDI, 5'd0, 5'd0, 16'd9);
    progBuf[3] = NOP;
    progBuf[4] = rInstr(OP_ADD, 5'd1, 5'd2, 5'd4);
    progBuf[5] = HLT;
    progLen = 6;
    applyStimulus();
    en = 1'b1;
    repeat (6) @(negedge clk);
    en = 1'b0;
    checkReg("midrst pre r1", 5'd1, 32'd3);
    checkReg("midrst pre r0", 5'd0, 32'd0);
    checkOutput("midrst pre retired", retired, 32'd3);
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    checkReg("midrst r4", 5'd4, 32'd0);
    checkReg("midrst r1", 5'd1, 32'd0);
    checkOutput("midrst pc", {22'd0, pc}, 32'd0);
    checkOutput("midrst retired", retired, 32'd0);
    checkOutput("midrst halted", {31'd0, halted}, 32'd0);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    checkOutput("restart pc", {22'd0, pc}, 32'd1);

    // JUMP to the last word, then PC wraps to 0 where HLT is placed while frozen.
    progBuf[0] = iInstr(OP_JUMP, 5'd0, 5'd0, 16'd1023);
    progLen = 1;
    loadWord(10'd1023, NOP);
    applyStimulus();
    en = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b0;
    loadWord(10'd0, HLT);
    checkOutput("wrap pc top", {22'd0, pc}, 32'd1023);
    en = 1'b1;
    @(negedge clk);
    checkOutput("wrap pc zero", {22'd0, pc}, 32'd0);
    runUntilHalt(50, cyc);
    checkOutput("wrap halted", {31'd0, halted}, 32'd1);
    checkOutput("wrap cycles", 32'(cyc), 32'd4);
    checkOutput("wrap retired", retired, 32'd3);
    checkOutput("wrap pc frozen", {22'd0, pc}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
